wb_select_stage: RTL and testbench

//  Parametrised N-way result selector with a registered, elastic output for the MIPS writeback path.
//  - Picks one of NUM_SRC candidate results (ALU, memory load, PC+4, LUI immediate, ...) using in_sel.
//  - Carries the destination register index and write enable along with the chosen result.
//  - Passes the packet through a 2-entry skid buffer with a valid/ready handshake.
//  - Sits between the MEM stage and the register-file write port, so writeback can stall without a combinational ready path.

---
 rtl/wb_pkg.sv | 32 +++
 rtl/skid_buffer.sv | 87 ++++++++
 rtl/wb_select_stage.sv | 93 +++++++++
 tb/tb_wb_select_stage.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the MIPS writeback path.
//   - WB_SRC_* : select encodings for the writeback result multiplexer
//   - WB_WIDTH / WB_DEST_W : default datapath and register-index widths
//   - wb_pkt_t : packet layout {sel_err, wen, dest, data} at default widths
// Parametrised blocks pack the same field order by concatenation so that
// non-default widths keep an identical layout.
// -----------------------------------------------------------------------------
package wb_pkg;

  localparam int WB_WIDTH  = 32;
  localparam int WB_DEST_W = 5;

  localparam logic [1:0] WB_SRC_ALU = 2'd0;
  localparam logic [1:0] WB_SRC_MEM = 2'd1;
  localparam logic [1:0] WB_SRC_PC4 = 2'd2;
  localparam logic [1:0] WB_SRC_LUI = 2'd3;

  typedef struct packed {
    logic                 sel_err;
    logic                 wen;
    logic [WB_DEST_W-1:0] dest;
    logic [WB_WIDTH-1:0]  data;
  } wb_pkt_t;

  // Total packed width of a writeback packet for arbitrary widths.
  function automatic int wb_pkt_width(input int width, input int dest_w);
    return width + dest_w + 2;
  endfunction

endpackage

// File: rtl/skid_buffer.sv
// -----------------------------------------------------------------------------
// skid_buffer
// Generic 2-entry elastic buffer with a valid/ready handshake on both sides.
// in_ready comes straight from a flop, so there is no combinational path
// from out_ready back to in_ready.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous flush, empties both entries
//   in_valid/in_ready   upstream handshake, in_data payload
//   out_valid/out_ready downstream handshake, out_data payload (main entry)
// -----------------------------------------------------------------------------
module skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_valid;
  logic [W-1:0] main_data;
  logic         skid_valid;
  logic [W-1:0] skid_data;
  logic         ready_q;

  logic accept;
  logic emit;
  logic main_free;

  // The main entry can take a new packet when it is empty or is being
  // drained this cycle. Acceptance uses the registered ready only.
  always_comb begin
    accept    = in_valid && ready_q;
    emit      = main_valid && out_ready;
    main_free = !main_valid || emit;
  end

  // Entry state update. A full skid always has priority for the main
  // entry so ordering is preserved; accept cannot coincide with a full
  // skid because ready_q is low then. Flush only clears the valid bits,
  // the payload registers keep their old contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      ready_q    <= 1'b1;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      ready_q    <= 1'b1;
    end else if (main_free) begin
      if (skid_valid) begin
        main_data  <= skid_data;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
        ready_q    <= 1'b1;
      end else if (accept) begin
        main_data  <= in_data;
        main_valid <= 1'b1;
        ready_q    <= 1'b1;
      end else begin
        main_valid <= 1'b0;
        ready_q    <= 1'b1;
      end
    end else if (accept) begin
      skid_data  <= in_data;
      skid_valid <= 1'b1;
      ready_q    <= 1'b0;
    end
  end

  // Outputs are the registered main entry and the registered ready.
  always_comb begin
    in_ready  = ready_q;
    out_valid = main_valid;
    out_data  = main_data;
  end

endmodule

// File: rtl/wb_select_stage.sv
// -----------------------------------------------------------------------------
// wb_select_stage
// N-way writeback result selector feeding a registered 2-entry skid buffer.
// Ports:
//   clk, rst_n, flush   clock, async active-low reset, synchronous flush
//   in_valid/in_ready   upstream handshake (in_ready registered)
//   in_sel              source select; out-of-range picks NUM_SRC-1
//   in_data             packed sources, source k at [k*WIDTH +: WIDTH]
//   in_dest, in_wen     destination register index and write enable
//   out_valid/out_ready downstream handshake to the register file
//   out_data, out_dest  selected result and destination
//   out_wen             write enable, never set for register $zero
//   sel_err             packet was captured with an out-of-range select
// -----------------------------------------------------------------------------
module wb_select_stage
  import wb_pkg::*;
#(
  parameter  int WIDTH   = 32,
  parameter  int NUM_SRC = 4,
  parameter  int DEST_W  = 5,
  localparam int SEL_W   = $clog2(NUM_SRC)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic [NUM_SRC*WIDTH-1:0] in_data,
  input  logic [DEST_W-1:0]        in_dest,
  input  logic                     in_wen,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [DEST_W-1:0]        out_dest,
  output logic                     out_wen,
  output logic                     sel_err
);

  localparam int PKT_W = WIDTH + DEST_W + 2;
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_SRC - 1);

  logic [SEL_W-1:0] eff_sel;
  logic             cap_err;
  logic             cap_wen;
  logic [WIDTH-1:0] cap_data;
  logic [PKT_W-1:0] cap_pkt;
  logic [PKT_W-1:0] held_pkt;

  // Clamp an out-of-range select onto the last source and flag it so the
  // downstream stage can see the packet was produced from a bad select.
  always_comb begin
    cap_err = (in_sel > LAST_SEL);
    eff_sel = cap_err ? LAST_SEL : in_sel;
  end

  // N-way multiplexer written as a loop so NUM_SRC need not be a power of
  // two. Register $zero must never be written, so wen is masked here at
  // capture time rather than at the register file.
  always_comb begin
    cap_data = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (SEL_W'(k) == eff_sel) begin
        cap_data = in_data[k*WIDTH +: WIDTH];
      end
    end
    cap_wen = in_wen && (in_dest != '0);
    cap_pkt = {cap_err, cap_wen, in_dest, cap_data};
  end

  skid_buffer #(
    .W(PKT_W)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (cap_pkt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (held_pkt)
  );

  // Unpack the held packet in the {sel_err, wen, dest, data} order.
  always_comb begin
    sel_err  = held_pkt[PKT_W-1];
    out_wen  = held_pkt[PKT_W-2];
    out_dest = held_pkt[WIDTH +: DEST_W];
    out_data = held_pkt[WIDTH-1:0];
  end

endmodule

// File: tb/tb_wb_select_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_select_stage
// Directed testbench for wb_select_stage. A 4-source instance carries most
// scenarios; a 3-source instance covers the out-of-range select clamp.
// -----------------------------------------------------------------------------
module tb_wb_select_stage;
  import wb_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_sel;
  logic [127:0] in_data;
  logic [4:0]   in_dest;
  logic         in_wen;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic [4:0]   out_dest;
  logic         out_wen;
  logic         sel_err;

  logic         in_valid3;
  logic         in_ready3;
  logic [95:0]  in_data3;
  logic         out_valid3;
  logic [31:0]  out_data3;
  logic [4:0]   out_dest3;
  logic         out_wen3;
  logic         sel_err3;

  int checks;
  int failures;

  wb_select_stage #(.WIDTH(32), .NUM_SRC(4), .DEST_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
    .in_data(in_data), .in_dest(in_dest), .in_wen(in_wen),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_dest(out_dest), .out_wen(out_wen), .sel_err(sel_err)
  );

  wb_select_stage #(.WIDTH(32), .NUM_SRC(3), .DEST_W(5)) dut3 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid3), .in_ready(in_ready3), .in_sel(in_sel),
    .in_data(in_data3), .in_dest(in_dest), .in_wen(in_wen),
    .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3),
    .out_dest(out_dest3), .out_wen(out_wen3), .sel_err(sel_err3)
  );

  // 100 MHz-style free running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge so outputs reflect it.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reset held for three cycles; state checked during and after.
  task automatic test_reset;
    rst_n = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_hold valid=%b ready=%b required valid=0 ready=1", out_valid, in_ready);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0 ||
        out_wen !== 1'b0 || sel_err !== 1'b0 || out_dest !== 5'd0) begin
      failures++;
      $display("[TB] FAIL reset_release valid=%b ready=%b data=%h wen=%b err=%b dest=%0d required 0/1/0/0/0/0",
               out_valid, in_ready, out_data, out_wen, sel_err, out_dest);
    end
  endtask

  // Back-to-back select sweep with the sink always ready.
  task automatic test_select_sweep;
    logic [31:0] exp_data [4];
    exp_data[0] = 32'h0000_00A0;
    exp_data[1] = 32'h0000_00B1;
    exp_data[2] = 32'h0000_00C2;
    exp_data[3] = 32'h0000_00D3;
    in_data   = {32'h0000_00D3, 32'h0000_00C2, 32'h0000_00B1, 32'h0000_00A0};
    out_ready = 1'b1;
    in_wen    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_sel   = 2'(i);
      in_dest  = 5'(i + 1);
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_data[i] || out_dest !== 5'(i + 1) ||
          in_ready !== 1'b1 || out_wen !== 1'b1 || sel_err !== 1'b0) begin
        failures++;
        $display("[TB] FAIL sweep_sel%0d valid=%b data=%h dest=%0d ready=%b wen=%b err=%b required 1/%h/%0d/1/1/0",
                 i, out_valid, out_data, out_dest, in_ready, out_wen, sel_err, exp_data[i], i + 1);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL sweep_drain valid=%b required 0", out_valid);
    end
  endtask

  // Two packets under backpressure, then release.
  task automatic test_backpressure;
    out_ready = 1'b0;
    in_sel    = WB_SRC_ALU;
    in_wen    = 1'b1;
    in_valid  = 1'b1;
    in_data   = {96'h0, 32'h1111_1111};
    in_dest   = 5'd3;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h1111_1111 || in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bp_p1 valid=%b data=%h ready=%b required 1/11111111/1", out_valid, out_data, in_ready);
    end
    in_data = {96'h0, 32'h2222_2222};
    in_dest = 5'd4;
    tick();
    checks++;
    if (out_data !== 32'h1111_1111 || out_dest !== 5'd3 || in_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bp_p2_skid data=%h dest=%0d ready=%b required 11111111/3/0", out_data, out_dest, in_ready);
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h1111_1111 || in_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bp_stable valid=%b data=%h ready=%b required 1/11111111/0", out_valid, out_data, in_ready);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h2222_2222 || out_dest !== 5'd4 || in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bp_p2_out valid=%b data=%h dest=%0d ready=%b required 1/22222222/4/1",
               out_valid, out_data, out_dest, in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bp_empty valid=%b ready=%b required 0/1", out_valid, in_ready);
    end
  endtask

  // Writes to register $zero must have their enable masked.
  task automatic test_zero_guard;
    out_ready = 1'b1;
    in_sel    = WB_SRC_MEM;
    in_data   = {64'h0, 32'hDEAD_BEEF, 32'h0};
    in_valid  = 1'b1;
    in_wen    = 1'b1;
    in_dest   = 5'd0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_wen !== 1'b0 || out_data !== 32'hDEAD_BEEF) begin
      failures++;
      $display("[TB] FAIL zero_dest valid=%b wen=%b data=%h required 1/0/deadbeef", out_valid, out_wen, out_data);
    end
    in_dest = 5'd5;
    tick();
    checks++;
    if (out_wen !== 1'b1 || out_dest !== 5'd5) begin
      failures++;
      $display("[TB] FAIL dest5_wen wen=%b dest=%0d required 1/5", out_wen, out_dest);
    end
    in_wen = 1'b0;
    tick();
    checks++;
    if (out_wen !== 1'b0) begin
      failures++;
      $display("[TB] FAIL wen_low wen=%b required 0", out_wen);
    end
    in_valid = 1'b0;
    in_wen   = 1'b1;
    tick();
  endtask

  // Out-of-range select on the 3-source instance clamps to source 2.
  task automatic test_sel_range;
    out_ready = 1'b1;
    in_data3  = {32'h0000_00C2, 32'h0000_00B1, 32'h0000_00A0};
    in_valid3 = 1'b1;
    in_sel    = 2'd3;
    in_dest   = 5'd7;
    tick();
    checks++;
    if (out_valid3 !== 1'b1 || out_data3 !== 32'h0000_00C2 || sel_err3 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL sel_oob valid=%b data=%h err=%b required 1/000000c2/1", out_valid3, out_data3, sel_err3);
    end
    in_sel = 2'd1;
    tick();
    checks++;
    if (out_data3 !== 32'h0000_00B1 || sel_err3 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL sel_inrange data=%h err=%b required 000000b1/0", out_data3, sel_err3);
    end
    in_sel = 2'd2;
    tick();
    checks++;
    if (out_data3 !== 32'h0000_00C2 || sel_err3 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL sel_last data=%h err=%b required 000000c2/0", out_data3, sel_err3);
    end
    in_valid3 = 1'b0;
    tick();
  endtask

  // Flush with the skid full, then flush racing an accept with skid empty.
  task automatic test_flush;
    out_ready = 1'b0;
    in_sel    = WB_SRC_ALU;
    in_valid  = 1'b1;
    in_data   = {96'h0, 32'hAAAA_0001};
    in_dest   = 5'd1;
    tick();
    in_data = {96'h0, 32'hAAAA_0002};
    in_dest = 5'd2;
    tick();
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flush_setup ready=%b required 0", in_ready);
    end
    in_data = {96'h0, 32'hAAAA_0003};
    in_dest = 5'd3;
    flush   = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'hAAAA_0001) begin
      failures++;
      $display("[TB] FAIL flush_full valid=%b ready=%b data=%h required 0/1/aaaa0001",
               out_valid, in_ready, out_data);
    end
    flush   = 1'b0;
    in_data = {96'h0, 32'hAAAA_0004};
    in_dest = 5'd4;
    tick();
    in_data = {96'h0, 32'hAAAA_0005};
    in_dest = 5'd5;
    flush   = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL flush_accept valid=%b ready=%b required 0/1", out_valid, in_ready);
    end
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("[TB] FAIL flush_no_emit cycle%0d valid=%b data=%h required valid 0", i, out_valid, out_data);
      end
    end
  endtask

  // Asynchronous reset in the middle of a stalled transfer.
  task automatic test_async_reset;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = {96'h0, 32'h5555_0001};
    in_dest   = 5'd9;
    tick();
    tick();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0 || out_wen !== 1'b0) begin
      failures++;
      $display("[TB] FAIL async_reset valid=%b ready=%b data=%h wen=%b required 0/1/0/0",
               out_valid, in_ready, out_data, out_wen);
    end
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_no_survivor valid=%b required 0", out_valid);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_valid3 = 1'b0;
    in_sel    = '0;
    in_data   = '0;
    in_data3  = '0;
    in_dest   = '0;
    in_wen    = 1'b0;
    out_ready = 1'b0;
    #2;
    test_reset();
    test_select_sweep();
    test_backpressure();
    test_zero_guard();
    test_sel_range();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
